// File: rtl/latch_wr_ctrl.sv
// Write controller for the D-latch stage: REQ/ACK in, setup/pulse/hold on EN/D.
// Optional LATCH_WR_CNT_EN adds WR_CNT, a saturating completed-pulse counter.
module latch_wr_ctrl #(
  parameter int WIDTH = 8,
  parameter int SETUP = 1,
  parameter int PULSE = 2,
  parameter int HOLD  = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ,
  input  logic [WIDTH-1:0] DIN,
  output logic             ACK,
  output logic             EN,
  output logic [WIDTH-1:0] D,
  output logic             BUSY
`ifdef LATCH_WR_CNT_EN
  ,
  output logic [15:0]      WR_CNT
`endif
);

  if (WIDTH < 1 || SETUP < 0 || SETUP > 15 ||
      PULSE < 1 || PULSE > 15 ||
      HOLD < 0 || HOLD > 15) begin : g_bad_param
    $error("latch_wr_ctrl: parameter out of range");
  end

  localparam logic [3:0] SL = 4'(SETUP > 0 ? SETUP - 1 : 0);
  localparam logic [3:0] PL = 4'(PULSE > 0 ? PULSE - 1 : 0);
  localparam logic [3:0] HL = 4'(HOLD > 0 ? HOLD - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       load;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    load    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (REQ && ACK) begin
          load = 1'b1;
          if (SETUP > 0) begin
            nxt     = ST_SETUP;
            cnt_nxt = SL;
          end else begin
            nxt     = ST_PULSE;
            cnt_nxt = PL;
          end
        end
      end
      ST_SETUP: begin
        if (cnt == 4'd0) begin
          nxt     = ST_PULSE;
          cnt_nxt = PL;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_PULSE: begin
        if (cnt == 4'd0) begin
          if (HOLD > 0) begin
            nxt     = ST_HOLD;
            cnt_nxt = HL;
          end else begin
            nxt     = ST_IDLE;
            cnt_nxt = 4'd0;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt == 4'd0) begin
          nxt     = ST_IDLE;
          cnt_nxt = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        nxt     = ST_IDLE;
        cnt_nxt = 4'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they track it glitch-free.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      EN    <= 1'b0;
      BUSY  <= 1'b0;
      ACK   <= 1'b0;
      D     <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      EN    <= (nxt == ST_PULSE);
      BUSY  <= (nxt != ST_IDLE);
      ACK   <= (nxt == ST_IDLE);
      if (load) D <= DIN;
    end
  end

`ifdef LATCH_WR_CNT_EN
  logic [15:0] wr_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_cnt <= 16'd0;
    end else if (EN && nxt != ST_PULSE && wr_cnt != 16'hFFFF) begin
      wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign WR_CNT = wr_cnt;
`endif

endmodule
